// File: rtl/branch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_sequencer
// Brief    : Program-counter owner. Sequences PC+4 fetch, absolute jumps and
//            conditional branches that wait for the ALU condition, with a
//            saturating taken-branch counter and a sticky condition-timeout
//            flag.
// Revision : 1.0 - initial release
// ============================================================================
module branch_pc_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  COND_TIMEOUT = 4,
  parameter int                  CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 jump_req,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 br_req,
  input  logic [PC_WIDTH-1:0]  br_imm,
  input  logic                 cond_valid,
  input  logic                 cond_taken,
  output logic [PC_WIDTH-1:0]  pcOut,
  output logic                 pc_valid,
  output logic                 wait_busy,
  output logic [CNT_WIDTH-1:0] taken_count,
  output logic                 cond_timeout_err
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [PC_WIDTH-1:0] C_PC_STEP   = PC_WIDTH'(4);
  localparam logic [3:0]          C_TMO_LIMIT = 4'(COND_TIMEOUT);

  state_t                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  pc_valid_q;
  logic                  wait_busy_q;
  logic [CNT_WIDTH-1:0]  taken_count_q;
  logic                  err_q;
  logic [PC_WIDTH-1:0]   target_q;
  logic [PC_WIDTH-1:0]   fallthrough_q;
  logic [3:0]            tmo_q;

  logic [PC_WIDTH-1:0]   pc_plus4_d;
  logic [PC_WIDTH-1:0]   br_target_d;
  logic [PC_WIDTH-1:0]   jump_addr_d;
  logic [3:0]            tmo_d;
  logic                  cnt_sat;
  logic                  unused_bits;

  // Address arithmetic: all modulo 2^PC_WIDTH, the offset shift drops the top
  // two bits of br_imm and jump addresses are forced word aligned.
  assign pc_plus4_d  = pc_q + C_PC_STEP;
  assign br_target_d = pc_plus4_d + {br_imm[PC_WIDTH-3:0], 2'b00};
  assign jump_addr_d = {jump_target[PC_WIDTH-1:2], 2'b00};
  assign tmo_d       = tmo_q + 4'd1;
  assign cnt_sat     = &taken_count_q;
  assign unused_bits = ^{br_imm[PC_WIDTH-1:PC_WIDTH-2], jump_target[1:0]};

  // Sequencer FSM: RUN fetches / decodes redirects, WAIT resolves a branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b1;
      wait_busy_q   <= 1'b0;
      taken_count_q <= '0;
      err_q         <= 1'b0;
      target_q      <= '0;
      fallthrough_q <= '0;
      tmo_q         <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (stall) begin
            // hold everything; redirect requests are dropped while stalled
          end else if (jump_req) begin
            pc_q <= jump_addr_d;
          end else if (br_req) begin
            target_q      <= br_target_d;
            fallthrough_q <= pc_plus4_d;
            tmo_q         <= '0;
            state_q       <= S_WAIT;
            pc_valid_q    <= 1'b0;
            wait_busy_q   <= 1'b1;
          end else begin
            pc_q <= pc_plus4_d;
          end
        end
        S_WAIT: begin
          if (cond_valid) begin
            // A condition arriving on the timeout cycle still resolves normally.
            pc_q <= cond_taken ? target_q : fallthrough_q;
            if (cond_taken && !cnt_sat) begin
              taken_count_q <= taken_count_q + 1'b1;
            end
            state_q     <= S_RUN;
            pc_valid_q  <= 1'b1;
            wait_busy_q <= 1'b0;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == C_TMO_LIMIT) begin
              pc_q        <= fallthrough_q;
              err_q       <= 1'b1;
              state_q     <= S_RUN;
              pc_valid_q  <= 1'b1;
              wait_busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_RUN;
          pc_valid_q  <= 1'b1;
          wait_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign pcOut            = pc_q;
  assign pc_valid         = pc_valid_q;
  assign wait_busy        = wait_busy_q;
  assign taken_count      = taken_count_q;
  assign cond_timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_pc_sequencer
// Brief    : Scenario tasks for branch_pc_sequencer; expected outputs are
//            queued with each stimulus cycle and popped after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump_req;
  logic [31:0] jump_target;
  logic        br_req;
  logic [31:0] br_imm;
  logic        cond_valid;
  logic        cond_taken;
  logic [31:0] pcOut;
  logic        pc_valid;
  logic        wait_busy;
  logic [15:0] taken_count;
  logic        cond_timeout_err;

  logic [31:0] s_pcOut;
  logic        s_pc_valid;
  logic        s_wait_busy;
  logic [1:0]  s_taken_count;
  logic        s_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        st, jr, br, cv, ct;
    logic [31:0] jt, imm;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        v, b;
    logic [15:0] cnt;
    logic        err;
    logic [1:0]  sat;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  stim_t s;
  exp_t  e;

  branch_pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .COND_TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_req(jump_req), .jump_target(jump_target),
    .br_req(br_req), .br_imm(br_imm), .cond_valid(cond_valid), .cond_taken(cond_taken),
    .pcOut(pcOut), .pc_valid(pc_valid), .wait_busy(wait_busy), .taken_count(taken_count),
    .cond_timeout_err(cond_timeout_err)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  branch_pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .COND_TIMEOUT(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .jump_req(jump_req), .jump_target(jump_target),
    .br_req(br_req), .br_imm(br_imm), .cond_valid(cond_valid), .cond_taken(cond_taken),
    .pcOut(s_pcOut), .pc_valid(s_pc_valid), .wait_busy(s_wait_busy), .taken_count(s_taken_count),
    .cond_timeout_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // Queue one stimulus cycle together with the outputs required after its edge.
  task automatic add(input logic st, input logic jr, input logic [31:0] jt, input logic br,
                     input logic [31:0] imm, input logic cv, input logic ct,
                     input logic [31:0] pc, input logic v, input logic b,
                     input logic [15:0] cnt, input logic err, input logic [1:0] sat);
    stim_q.push_back('{st: st, jr: jr, br: br, cv: cv, ct: ct, jt: jt, imm: imm});
    exp_q.push_back('{pc: pc, v: v, b: b, cnt: cnt, err: err, sat: sat});
  endtask

  task automatic apply(input stim_t x);
    stall = x.st; jump_req = x.jr; jump_target = x.jt; br_req = x.br;
    br_imm = x.imm; cond_valid = x.cv; cond_taken = x.ct;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {32'h0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h v=%b b=%b cnt=%h err=%b required pc=0 v=1 b=0 cnt=0 err=0",
               pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err);
    end
    @(posedge clk); #1; reset = 1'b0;
    add(0,0,0,0,0,0,0, 32'h4, 1,0,16'd0,0,0);
    add(0,0,0,0,0,0,0, 32'h8, 1,0,16'd0,0,0);
    add(0,0,0,0,0,0,0, 32'hC, 1,0,16'd0,0,0);
    add(0,0,0,0,0,0,0, 32'h10,1,0,16'd0,0,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL reset_seq: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_branch;
    add(0,0,0,1,32'd3,0,0,        32'h10,0,1,16'd0,0,0);
    add(0,0,0,0,0,1,1,            32'h20,1,0,16'd1,0,0);
    add(0,1,32'h10,0,0,0,0,       32'h10,1,0,16'd1,0,0);
    add(0,0,0,1,32'hFFFF_FFFE,0,0,32'h10,0,1,16'd1,0,0);
    add(0,0,0,0,0,1,0,            32'h14,1,0,16'd1,0,0);
    add(0,1,32'h10,0,0,0,0,       32'h10,1,0,16'd1,0,0);
    add(0,0,0,1,32'hFFFF_FFFE,0,0,32'h10,0,1,16'd1,0,0);
    add(0,0,0,0,0,1,1,            32'hC, 1,0,16'd2,0,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL branch: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_jump_stall;
    add(0,1,32'h40,0,0,0,0,       32'h40, 1,0,16'd2,0,0);
    add(0,1,32'h103,1,32'd5,0,0,  32'h100,1,0,16'd2,0,0);
    add(1,1,32'h200,1,32'd5,0,0,  32'h100,1,0,16'd2,0,0);
    add(1,0,0,0,0,0,0,            32'h100,1,0,16'd2,0,0);
    add(0,0,0,0,0,1,1,            32'h104,1,0,16'd2,0,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL jump_stall: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_cond_at_timeout;
    add(0,0,0,1,32'd2,0,0,        32'h104,0,1,16'd2,0,0);
    add(1,1,32'h300,0,0,0,0,      32'h104,0,1,16'd2,0,0);
    add(0,0,0,1,32'd9,0,0,        32'h104,0,1,16'd2,0,0);
    add(0,0,0,0,0,0,0,            32'h104,0,1,16'd2,0,0);
    add(0,0,0,0,0,1,1,            32'h110,1,0,16'd3,0,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL cond_at_timeout: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_timeout;
    add(0,1,32'h8,0,0,0,0,        32'h8,1,0,16'd3,0,0);
    add(0,0,0,1,32'd7,0,0,        32'h8,0,1,16'd3,0,0);
    add(0,0,0,0,0,0,0,            32'h8,0,1,16'd3,0,0);
    add(0,0,0,0,0,0,0,            32'h8,0,1,16'd3,0,0);
    add(0,0,0,0,0,0,0,            32'h8,0,1,16'd3,0,0);
    add(0,0,0,0,0,0,1,            32'hC,1,0,16'd3,1,0);
    add(0,0,0,1,32'd1,0,0,        32'hC,0,1,16'd3,1,0);
    add(0,0,0,0,0,1,0,            32'h10,1,0,16'd3,1,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL timeout: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_wrap;
    add(0,1,32'hFFFF_FFFF,0,0,0,0,  32'hFFFF_FFFC,1,0,16'd3,1,0);
    add(0,0,0,0,0,0,0,              32'h0,1,0,16'd3,1,0);
    add(0,0,0,1,32'hC000_0001,0,0,  32'h0,0,1,16'd3,1,0);
    add(0,0,0,0,0,1,1,              32'h8,1,0,16'd4,1,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL wrap: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    add(0,0,0,1,32'd0,0,0,          32'h8,0,1,16'd4,1,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL mid_wait_entry: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
    apply('{st: 0, jr: 0, br: 0, cv: 0, ct: 0, jt: 0, imm: 0});
    #2; reset = 1'b1; #1;
    n_cmp++;
    if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {32'h0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_mid_wait: got pc=%h v=%b b=%b cnt=%h err=%b required pc=0 v=1 b=0 cnt=0 err=0",
               pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err);
    end
    @(posedge clk); #1; reset = 1'b0;
    add(0,0,0,0,0,0,0,              32'h4,1,0,16'd0,0,0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err} !== {e.pc, e.v, e.b, e.cnt, e.err}) begin
        n_fail++;
        $display("FAIL after_reset: got pc=%h v=%b b=%b cnt=%h err=%b required pc=%h v=%b b=%b cnt=%h err=%b",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, e.pc, e.v, e.b, e.cnt, e.err);
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] p;
    p = 32'h4;
    for (int i = 0; i < 5; i++) begin
      add(0,0,0,1,32'd0,0,0, p,          0,1,16'(i),  0, (i   > 3) ? 2'd3 : 2'(i));
      add(0,0,0,0,0,1,1,     p + 32'd4,  1,0,16'(i+1),0, (i+1 > 3) ? 2'd3 : 2'(i+1));
      p = p + 32'd4;
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); @(posedge clk); #1; e = exp_q.pop_front(); n_cmp++;
      if ({pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, s_taken_count} !==
          {e.pc, e.v, e.b, e.cnt, e.err, e.sat}) begin
        n_fail++;
        $display("FAIL saturation: got pc=%h v=%b b=%b cnt=%h err=%b satcnt=%0d required pc=%h v=%b b=%b cnt=%h err=%b satcnt=%0d",
                 pcOut, pc_valid, wait_busy, taken_count, cond_timeout_err, s_taken_count,
                 e.pc, e.v, e.b, e.cnt, e.err, e.sat);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    apply('{st: 0, jr: 0, br: 0, cv: 0, ct: 0, jt: 0, imm: 0});
    test_reset();
    test_branch();
    test_jump_stall();
    test_cond_at_timeout();
    test_timeout();
    test_wrap();
    test_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
